// File: rtl/wash_seq_ctrl.sv
// ---------------------------------------------------------------------------
// wash_seq_ctrl
// Washing-machine programme sequencer. Walks the selected programme through
// its wash, rinse and spin phases, counting each phase down on the 1 Hz tick,
// and finishes with a timed buzzer before returning to IDLE.
//
// Optional feature macro: WASH_DOOR_LOCK_EN
//   When defined, adds the door_open input and the door_lock output. An open
//   door blocks starting and pauses an active programme.
//
// Ports
//   clk_N        in   system clock
//   rst          in   synchronous active-high reset
//   tick         in   one-cycle enable, once per second
//   start_pause  in   start from IDLE, otherwise toggle run/pause
//   mode_next    in   advance programme (IDLE only), wraps 5 -> 0
//   weight_next  in   advance load (IDLE only), wraps 3 -> 0
//   door_open    in   door sensor (WASH_DOOR_LOCK_EN only)
//   mode         out  selected programme 0..5
//   weight       out  selected load 0..3
//   state        out  current state code
//   running      out  countdown is advancing
//   remain       out  ticks left in the current phase
//   rinse_left   out  rinse passes not yet completed
//   light_xi     out  wash block still pending
//   light_piao   out  rinse block still pending
//   light_tuo    out  spin block still pending
//   valve_in     out  fill valve
//   valve_out    out  drain valve
//   buzzer       out  completion buzzer
//   door_lock    out  door held shut (WASH_DOOR_LOCK_EN only)
// ---------------------------------------------------------------------------
module wash_seq_ctrl #(
    parameter int unsigned TIME_W  = 8,
    parameter int unsigned FILL_T  = 3,
    parameter int unsigned WASH_T  = 5,
    parameter int unsigned DRAIN_T = 2,
    parameter int unsigned DRY_T   = 2,
    parameter int unsigned RINSE_T = 3,
    parameter int unsigned SPIN_T  = 4,
    parameter int unsigned RINSES  = 2,
    parameter int unsigned BUZZ_T  = 3
) (
    input  logic              clk_N,
    input  logic              rst,
    input  logic              tick,
    input  logic              start_pause,
    input  logic              mode_next,
    input  logic              weight_next,
`ifdef WASH_DOOR_LOCK_EN
    input  logic              door_open,
    output logic              door_lock,
`endif
    output logic [2:0]        mode,
    output logic [1:0]        weight,
    output logic [3:0]        state,
    output logic              running,
    output logic [TIME_W-1:0] remain,
    output logic [2:0]        rinse_left,
    output logic              light_xi,
    output logic              light_piao,
    output logic              light_tuo,
    output logic              valve_in,
    output logic              valve_out,
    output logic              buzzer
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FILL   = 4'd1,
        WASH   = 4'd2,
        RDRAIN = 4'd3,
        RDRY   = 4'd4,
        RFILL  = 4'd5,
        RINSE  = 4'd6,
        SDRAIN = 4'd7,
        SPIN   = 4'd8,
        DONE   = 4'd9
    } state_t;

    // Blocks contained in a programme, packed as {wash, rinse, spin}.
    function automatic logic [2:0] prog_blocks(input logic [2:0] m);
        case (m)
            3'd0:    prog_blocks = 3'b111;
            3'd1:    prog_blocks = 3'b100;
            3'd2:    prog_blocks = 3'b110;
            3'd3:    prog_blocks = 3'b010;
            3'd4:    prog_blocks = 3'b011;
            3'd5:    prog_blocks = 3'b001;
            default: prog_blocks = 3'b000;
        endcase
    endfunction

    function automatic logic [TIME_W-1:0] phase_dur(input state_t s, input logic [1:0] w);
        case (s)
            FILL, RFILL:    phase_dur = TIME_W'(FILL_T) + TIME_W'(w);
            WASH:           phase_dur = TIME_W'(WASH_T);
            RDRAIN, SDRAIN: phase_dur = TIME_W'(DRAIN_T);
            RDRY:           phase_dur = TIME_W'(DRY_T);
            RINSE:          phase_dur = TIME_W'(RINSE_T);
            SPIN:           phase_dur = TIME_W'(SPIN_T);
            DONE:           phase_dur = TIME_W'(BUZZ_T);
            default:        phase_dur = '0;
        endcase
    endfunction

    // Programme phases are ordered wash < rinse < spin, so a block is still
    // pending exactly while the state code has not passed its last phase.
    function automatic logic [2:0] lights_for(input state_t s, input logic [2:0] m);
        logic [2:0] b;
        b = prog_blocks(m);
        case (s)
            IDLE:    lights_for = b;
            DONE:    lights_for = 3'b000;
            default: lights_for = {b[2] && (s <= WASH), b[1] && (s <= RINSE), b[0] && (s <= SPIN)};
        endcase
    endfunction

    state_t            cur_state, next_state, first_st, adv_st;
    logic [TIME_W-1:0] remain_n;
    logic              running_n, buzzer_n, door_blocked;
    logic [2:0]        rinse_n, mode_n, blk, lights_n;
    logic [1:0]        weight_n;

`ifdef WASH_DOOR_LOCK_EN
    assign door_blocked = door_open;
    assign door_lock    = (cur_state != IDLE) && (cur_state != DONE);
`else
    assign door_blocked = 1'b0;
`endif

    assign blk       = prog_blocks(mode);
    assign state     = cur_state;
    assign valve_in  = running && ((cur_state == FILL) || (cur_state == RFILL));
    assign valve_out = running && ((cur_state == RDRAIN) || (cur_state == SDRAIN));

    // Where the programme begins and where the current phase hands over when
    // its countdown expires. A rinse pass repeats while passes remain.
    always_comb begin
        first_st = blk[2] ? FILL : blk[1] ? RDRAIN : blk[0] ? SDRAIN : IDLE;
        case (cur_state)
            FILL:    adv_st = WASH;
            WASH:    adv_st = blk[1] ? RDRAIN : (blk[0] ? SDRAIN : DONE);
            RDRAIN:  adv_st = RDRY;
            RDRY:    adv_st = RFILL;
            RFILL:   adv_st = RINSE;
            RINSE:   adv_st = ((rinse_left - 3'd1) != 3'd0) ? RDRAIN : (blk[0] ? SDRAIN : DONE);
            SDRAIN:  adv_st = SPIN;
            SPIN:    adv_st = DONE;
            default: adv_st = IDLE;
        endcase
    end

    // Next-state logic. A start_pause pulse always wins over a coincident
    // tick, and in IDLE it also swallows coincident selection pulses.
    always_comb begin
        next_state = cur_state;
        remain_n   = remain;
        running_n  = running;
        rinse_n    = rinse_left;
        mode_n     = mode;
        weight_n   = weight;
        buzzer_n   = buzzer;
        case (cur_state)
            IDLE: begin
                if (start_pause) begin
                    if (!door_blocked && (first_st != IDLE)) begin
                        next_state = first_st;
                        remain_n   = phase_dur(first_st, weight);
                        running_n  = 1'b1;
                        rinse_n    = 3'(RINSES);
                    end
                end else begin
                    if (mode_next)
                        mode_n = (mode == 3'd5) ? 3'd0 : mode + 3'd1;
                    if (weight_next)
                        weight_n = weight + 2'd1;
                end
            end
            FILL, WASH, RDRAIN, RDRY, RFILL, RINSE, SDRAIN, SPIN: begin
                if (door_blocked) begin
                    running_n = 1'b0;
                end else if (start_pause) begin
                    running_n = ~running;
                end else if (tick && running) begin
                    if (remain == TIME_W'(1)) begin
                        next_state = adv_st;
                        remain_n   = phase_dur(adv_st, weight);
                        if (cur_state == RINSE)
                            rinse_n = rinse_left - 3'd1;
                        if (adv_st == DONE) begin
                            running_n = 1'b0;
                            buzzer_n  = 1'b1;
                        end
                    end else begin
                        remain_n = remain - TIME_W'(1);
                    end
                end
            end
            DONE: begin
                // The buzzer countdown runs even though running is low.
                if (tick) begin
                    if (remain == TIME_W'(1)) begin
                        next_state = IDLE;
                        remain_n   = '0;
                        buzzer_n   = 1'b0;
                    end else begin
                        remain_n = remain - TIME_W'(1);
                    end
                end
            end
            default: begin
                next_state = IDLE;
                running_n  = 1'b0;
                buzzer_n   = 1'b0;
                remain_n   = '0;
            end
        endcase
        lights_n = lights_for(next_state, mode_n);
    end

    // State register. Indicators are registered from the next state so that
    // reset clears them like every other output.
    always_ff @(posedge clk_N) begin
        if (rst) begin
            cur_state  <= IDLE;
            remain     <= '0;
            running    <= 1'b0;
            rinse_left <= 3'd0;
            mode       <= 3'd0;
            weight     <= 2'd0;
            buzzer     <= 1'b0;
            light_xi   <= 1'b0;
            light_piao <= 1'b0;
            light_tuo  <= 1'b0;
        end else begin
            cur_state  <= next_state;
            remain     <= remain_n;
            running    <= running_n;
            rinse_left <= rinse_n;
            mode       <= mode_n;
            weight     <= weight_n;
            buzzer     <= buzzer_n;
            {light_xi, light_piao, light_tuo} <= lights_n;
        end
    end

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wash_seq_ctrl
// Self-checking bench for wash_seq_ctrl (default build, door lock disabled).
// A phase-list model of the programme is compared with the DUT every cycle,
// and directed scenarios pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_wash_seq_ctrl;

    localparam int TIME_W  = 8;
    localparam int FILL_T  = 3;
    localparam int WASH_T  = 5;
    localparam int DRAIN_T = 2;
    localparam int DRY_T   = 2;
    localparam int RINSE_T = 3;
    localparam int SPIN_T  = 4;
    localparam int RINSES  = 2;
    localparam int BUZZ_T  = 3;

    logic              clk_N = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic              start_pause = 1'b0;
    logic              mode_next = 1'b0;
    logic              weight_next = 1'b0;
    logic [2:0]        mode;
    logic [1:0]        weight;
    logic [3:0]        state;
    logic              running;
    logic [TIME_W-1:0] remain;
    logic [2:0]        rinse_left;
    logic              light_xi, light_piao, light_tuo;
    logic              valve_in, valve_out, buzzer;

    int n_tests = 0;
    int n_fail  = 0;

    wash_seq_ctrl #(
        .TIME_W(TIME_W), .FILL_T(FILL_T), .WASH_T(WASH_T), .DRAIN_T(DRAIN_T),
        .DRY_T(DRY_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T), .RINSES(RINSES),
        .BUZZ_T(BUZZ_T)
    ) dut (
        .clk_N(clk_N), .rst(rst), .tick(tick), .start_pause(start_pause),
        .mode_next(mode_next), .weight_next(weight_next),
        .mode(mode), .weight(weight), .state(state), .running(running),
        .remain(remain), .rinse_left(rinse_left),
        .light_xi(light_xi), .light_piao(light_piao), .light_tuo(light_tuo),
        .valve_in(valve_in), .valve_out(valve_out), .buzzer(buzzer)
    );

    always #5 clk_N = ~clk_N;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Programme model: a flat list of (state code, duration) phases.
    int ph_code[$];
    int ph_dur[$];
    int m_mode = 0, m_weight = 0, m_idx = 0, m_remain = 0, m_rinse_left = 0;
    bit m_active = 0, m_done = 0, m_running = 0, m_just_reset = 0;

    function automatic bit has_w(int m); return m inside {0, 1, 2}; endfunction
    function automatic bit has_r(int m); return m inside {0, 2, 3, 4}; endfunction
    function automatic bit has_s(int m); return m inside {0, 4, 5}; endfunction

    task automatic build_phases(input int m, input int w);
        ph_code.delete();
        ph_dur.delete();
        if (has_w(m)) begin
            ph_code.push_back(1); ph_dur.push_back(FILL_T + w);
            ph_code.push_back(2); ph_dur.push_back(WASH_T);
        end
        if (has_r(m)) begin
            for (int p = 0; p < RINSES; p++) begin
                ph_code.push_back(3); ph_dur.push_back(DRAIN_T);
                ph_code.push_back(4); ph_dur.push_back(DRY_T);
                ph_code.push_back(5); ph_dur.push_back(FILL_T + w);
                ph_code.push_back(6); ph_dur.push_back(RINSE_T);
            end
        end
        if (has_s(m)) begin
            ph_code.push_back(7); ph_dur.push_back(DRAIN_T);
            ph_code.push_back(8); ph_dur.push_back(SPIN_T);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_mode = 0; m_weight = 0; m_idx = 0; m_remain = 0; m_rinse_left = 0;
            m_active = 0; m_done = 0; m_running = 0; m_just_reset = 1;
        end else begin
            m_just_reset = 0;
            if (m_done) begin
                if (tick) begin
                    m_remain--;
                    if (m_remain == 0) m_done = 0;
                end
            end else if (m_active) begin
                if (start_pause) begin
                    m_running = !m_running;
                end else if (tick && m_running) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        if (ph_code[m_idx] == 6) m_rinse_left--;
                        m_idx++;
                        if (m_idx == ph_code.size()) begin
                            m_active = 0; m_done = 1; m_running = 0; m_remain = BUZZ_T;
                        end else begin
                            m_remain = ph_dur[m_idx];
                        end
                    end
                end
            end else begin
                if (start_pause) begin
                    build_phases(m_mode, m_weight);
                    m_active = 1; m_idx = 0; m_remain = ph_dur[0];
                    m_running = 1; m_rinse_left = RINSES;
                end else begin
                    if (mode_next) m_mode = (m_mode + 1) % 6;
                    if (weight_next) m_weight = (m_weight + 1) % 4;
                end
            end
        end
    endtask

    task automatic compare_all();
        int  exp_state;
        bit  lx, lp, lt;
        exp_state = m_done ? 9 : (m_active ? ph_code[m_idx] : 0);
        lx = 0; lp = 0; lt = 0;
        if (!m_just_reset && !m_done) begin
            if (m_active) begin
                for (int i = m_idx; i < ph_code.size(); i++) begin
                    if (ph_code[i] inside {1, 2}) lx = 1;
                    if (ph_code[i] inside {[3:6]}) lp = 1;
                    if (ph_code[i] inside {7, 8}) lt = 1;
                end
            end else begin
                lx = has_w(m_mode); lp = has_r(m_mode); lt = has_s(m_mode);
            end
        end
        check("state", state, exp_state);
        check("remain", remain, m_remain);
        check("running", running, m_running);
        check("rinse_left", rinse_left, m_rinse_left);
        check("mode", mode, m_mode);
        check("weight", weight, m_weight);
        check("buzzer", buzzer, m_done);
        check("valve_in", valve_in, m_running && exp_state inside {1, 5});
        check("valve_out", valve_out, m_running && exp_state inside {3, 7});
        check("light_xi", light_xi, lx);
        check("light_piao", light_piao, lp);
        check("light_tuo", light_tuo, lt);
    endtask

    // Compare process: advance the model on each edge, then check the DUT.
    always @(posedge clk_N) begin
        model_update();
        #1;
        compare_all();
    end

    // One clock cycle of stimulus; pulses last exactly one edge.
    task automatic applyStimulus(input bit r, input bit sp, input bit mn, input bit wn, input bit tk);
        @(negedge clk_N);
        rst = r; start_pause = sp; mode_next = mn; weight_next = wn; tick = tk;
        @(posedge clk_N);
        #3;
        rst = 0; start_pause = 0; mode_next = 0; weight_next = 0; tick = 0;
    endtask

    task automatic tickN(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 1);
    endtask

    task automatic tickUntil(input int code, input int limit);
        int cnt;
        cnt = 0;
        while (state != code && cnt < limit) begin
            tickN(1);
            cnt++;
        end
        check("reach_state", state, code);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, r10, r22, in_seen, bad;

        // Reset state
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check("rst_state", state, 0);
        check("rst_light_xi", light_xi, 0);
        applyStimulus(0, 0, 0, 0, 0);
        check("idle_light_tuo", light_tuo, 1);

        // Selection wrap
        repeat (6) applyStimulus(0, 0, 1, 0, 0);
        check("mode_wrap", mode, 0);
        repeat (4) applyStimulus(0, 0, 0, 1, 0);
        check("weight_wrap", weight, 0);

        // Wash only, light load
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        check("w1_state", state, 1);
        check("w1_remain", remain, 3);
        check("w1_valve_in", valve_in, 1);
        tickN(7);
        check("w1_wash_state", state, 2);
        check("w1_wash_remain", remain, 1);
        tickN(1);
        check("w1_done_state", state, 9);
        check("w1_done_buzzer", buzzer, 1);
        check("w1_done_running", running, 0);
        tickN(2);
        check("w1_buzz_hold", state, 9);
        tickN(1);
        check("w1_idle_state", state, 0);
        check("w1_idle_buzzer", buzzer, 0);
        check("w1_idle_mode", mode, 1);

        // Pause freezes the countdown
        applyStimulus(0, 1, 0, 0, 0);
        tickN(2);
        applyStimulus(0, 1, 0, 0, 0);
        tickN(10);
        check("p_state", state, 1);
        check("p_remain", remain, 1);
        check("p_valve_in", valve_in, 0);
        applyStimulus(0, 1, 0, 0, 0);
        tickN(1);
        check("p_resume_state", state, 2);
        check("p_resume_remain", remain, 5);

        // Selection is locked out while active
        applyStimulus(0, 0, 1, 0, 0);
        check("lock_mode", mode, 1);
        applyStimulus(0, 0, 0, 1, 0);
        check("lock_weight", weight, 0);
        tickUntil(0, 20);

        // Simultaneous events
        applyStimulus(0, 1, 1, 0, 0);
        check("sim_start_state", state, 1);
        check("sim_start_mode", mode, 1);
        tickN(1);
        applyStimulus(0, 1, 0, 0, 1);
        check("sim_pause_running", running, 0);
        check("sim_pause_remain", remain, 2);
        applyStimulus(0, 1, 0, 0, 0);
        tickUntil(0, 30);

        // Full programme, heavy load
        repeat (5) applyStimulus(0, 0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 1, 0);
        check("full_mode", mode, 0);
        check("full_weight", weight, 2);
        applyStimulus(0, 1, 0, 0, 0);
        cnt = 0; r10 = -1; r22 = -1; in_seen = 0; bad = 0;
        while (state != 9 && cnt < 100) begin
            tickN(1);
            cnt++;
            if (cnt == 10) r10 = rinse_left;
            if (cnt == 22) r22 = rinse_left;
            if (valve_in) begin
                in_seen++;
                if (!(state inside {1, 5})) bad++;
            end
        end
        check("full_ticks", cnt, 40);
        check("full_rinse_t10", r10, 2);
        check("full_rinse_t22", r22, 1);
        check("full_rinse_end", rinse_left, 0);
        check("full_valve_in_ticks", in_seen, 14);
        check("full_valve_in_bad", bad, 0);
        tickUntil(0, 10);

        // Reset during RINSE
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        tickUntil(6, 30);
        applyStimulus(1, 0, 0, 0, 0);
        check("rr_state", state, 0);
        check("rr_remain", remain, 0);
        check("rr_running", running, 0);
        check("rr_mode", mode, 0);
        check("rr_weight", weight, 0);
        check("rr_rinse_left", rinse_left, 0);
        check("rr_light_piao", light_piao, 0);
        check("rr_buzzer", buzzer, 0);
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_seq_ctrl.md
Name: wash_seq_ctrl

Overview:
- Parametrised washing-machine programme sequencer; next generation of the top-level controller FSM.
- Owns its phase countdown internally; no separate timer block.
- Adds a configurable number of rinse passes, weight-scaled fill time, pause that freezes the countdown, and a timed buzzer on completion.
- Sits between the debounced button pulses / 1 Hz tick and the LED, valve and seven-segment display logic.

Parameters:
- TIME_W, 8: width of the phase countdown and of every duration parameter.
- FILL_T, 3: base fill duration in ticks; the actual fill is FILL_T + weight.
- WASH_T, 5: wash duration in ticks.
- DRAIN_T, 2: drain duration in ticks, for both rinse drains and the spin drain.
- DRY_T, 2: spin-dry duration inside each rinse pass, in ticks.
- RINSE_T, 3: agitation duration of each rinse, in ticks.
- SPIN_T, 4: final spin duration in ticks.
- RINSES, 2: number of rinse passes, legal range 1..7.
- BUZZ_T, 3: number of ticks the buzzer stays on in DONE.

Ports:
- clk_N  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle enable, once per second.
- start_pause  in  1  one-cycle pulse; starts from IDLE, otherwise toggles run/pause.
- mode_next  in  1  one-cycle pulse; advances the programme, honoured only in IDLE.
- weight_next  in  1  one-cycle pulse; advances the weight, honoured only in IDLE.
- mode  out  3  selected programme, 0..5.
- weight  out  2  selected load, 0..3.
- state  out  4  current state code.
- running  out  1  high while the countdown advances.
- remain  out  TIME_W  ticks left in the current phase.
- rinse_left  out  3  rinse passes not yet completed.
- light_xi, light_piao, light_tuo  out  1 each  wash, rinse and spin phase indicators.
- valve_in, valve_out  out  1 each  fill and drain valve drives.
- buzzer  out  1  completion buzzer.

Behaviour:
- Clocking: all state updates on posedge clk_N.
- Reset: rst overrides everything, including mid-cycle. Every output goes to 0; state=IDLE(0).
- State codes: IDLE=0, FILL=1, WASH=2, RDRAIN=3, RDRY=4, RFILL=5, RINSE=6, SDRAIN=7, SPIN=8, DONE=9. Codes 10..15 return to IDLE on the next edge.
- Programmes by mode:
  - 0: wash, rinse, spin.
  - 1: wash only.
  - 2: wash, rinse.
  - 3: rinse only.
  - 4: rinse, spin.
  - 5: spin only.
- Wash block: FILL -> WASH.
- Rinse pass: RDRAIN -> RDRY -> RFILL -> RINSE, repeated RINSES times.
- Spin block: SDRAIN -> SPIN.
- After the last block of the programme, go to DONE.
- IDLE inputs:
  - mode_next: mode wraps 5->0.
  - weight_next: weight wraps 3->0.
  - start_pause: running=1; enter the first phase of the programme; load remain; rinse_left=RINSES.
  - If start_pause and mode_next/weight_next arrive on the same edge, start wins and the other pulses are dropped.
- Phase durations: FILL and RFILL last FILL_T+weight; DONE lasts BUZZ_T; other phases use their own parameter.
- Countdown rules:
  - On tick with running=1, remain decrements.
  - If remain==1 on that tick, the state advances on the same edge and remain loads the next phase's duration.
  - Latency: a phase of N ticks exits on its Nth tick.
- Rinse count: rinse_left decrements on RINSE exit. A further pass starts if the new value is non-zero.
- Pause:
  - start_pause while active toggles running.
  - With running=0, state and remain hold, tick is ignored, and valves are forced to 0.
  - start_pause together with tick: the toggle applies and that tick is ignored.
- DONE:
  - Entry sets running=0 and buzzer=1.
  - BUZZ_T ticks are counted regardless of running; then IDLE, buzzer=0, mode and weight retained.
  - start_pause in DONE is ignored.
- Valve drives: valve_in=1 in FILL/RFILL, valve_out=1 in RDRAIN/SDRAIN, both only while running.
- Indicators:
  - In IDLE, light_xi/light_piao/light_tuo show the blocks contained in mode.
  - While active, each stays 1 until its block has completed.
  - All are 0 in DONE.
- Width rule: FILL_T+weight is computed in TIME_W bits. A sum that overflows TIME_W is an illegal parameter choice.

Optional Feature:
- Macro: WASH_DOOR_LOCK_EN.
- When defined:
  - Adds input door_open (1 bit) and output door_lock (1 bit).
  - start_pause in IDLE is ignored while door_open=1.
  - door_lock=1 whenever state is neither IDLE nor DONE.
  - door_open=1 while active forces running=0 on the next edge.
  - The door being closed does not auto-resume; start_pause is required.
- When undefined: no door port and no door_lock port; behaviour is exactly as above.

Test Plan:
- Wash only, light load: mode=1, weight=0, start -> FILL for 3 ticks, WASH for 5; after tick 8 state=9, buzzer=1; after tick 11 state=0, buzzer=0.
- Full programme, heavy load: mode=0, weight=2, RINSES=2 -> total 40 ticks to DONE; rinse_left steps 2->1->0; valve_in=1 only in states 1 and 5.
- Pause: mode=1, start, 2 ticks, pause, 10 ticks -> state=1, remain=1, valve_in=0. Resume, 1 tick -> state=2, remain=5.
- Selection wrap and lockout: 6 mode_next pulses in IDLE -> mode=0. 4 weight_next pulses -> weight=0. mode_next while running -> mode unchanged.
- Simultaneous events: start_pause with tick in FILL -> running=0, remain unchanged. rst asserted in RINSE -> next edge state=0, all outputs 0.
- With WASH_DOOR_LOCK_EN: start while door_open=1 -> stays IDLE. door_open raised in WASH -> running=0, door_lock stays 1.
